// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: operation codes and FSM states.
package shifter_pkg;

  // Operation codes; the two reserved codes behave as pass.
  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_LSL  = 3'b001,
    OP_LSR  = 3'b010,
    OP_ASR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  // Controller states; busy is asserted only in ST_SHIFT.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit combinational shift/rotate step with the bit that leaves the word.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_value,
  input  op_e              i_op,
  output logic [WIDTH-1:0] o_value,
  output logic             o_bit
);

  // Select the single-bit step; pass and reserved codes hold with a zero out-bit.
  always_comb begin
    o_value = i_value;
    o_bit   = 1'b0;
    case (i_op)
      OP_LSL: begin
        o_value = {i_value[WIDTH-2:0], 1'b0};
        o_bit   = i_value[WIDTH-1];
      end
      OP_LSR: begin
        o_value = {1'b0, i_value[WIDTH-1:1]};
        o_bit   = i_value[0];
      end
      OP_ASR: begin
        o_value = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
        o_bit   = i_value[0];
      end
      OP_ROL: begin
        o_value = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
        o_bit   = i_value[WIDTH-1];
      end
      OP_ROR: begin
        o_value = {i_value[0], i_value[WIDTH-1:1]};
        o_bit   = i_value[0];
      end
      default: begin
        o_value = i_value;
        o_bit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Sequential shifter: performs an amt-bit shift/rotate one bit per clock.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] sout,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_sout;
  logic [AW-1:0]    r_cnt;
  op_e              r_op;
  logic             r_carry;
  logic [WIDTH-1:0] w_step_value;
  logic             w_step_bit;
  logic             w_load;
  logic             w_step_en;

  // A start is only honoured when no operation is running.
  assign w_load    = (r_state != ST_SHIFT) && start;
  assign w_step_en = (r_state == ST_SHIFT) && (r_cnt != '0);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_value (r_sout),
    .i_op    (r_op),
    .o_value (w_step_value),
    .o_bit   (w_step_bit)
  );

  // State register; reset aborts any running operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status decode.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == '0) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = start ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Working register: load on accepted start, one step per cycle while cnt is non-zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sout  <= '0;
      r_cnt   <= '0;
      r_op    <= OP_PASS;
      r_carry <= 1'b0;
    end else if (w_load) begin
      r_sout  <= in;
      r_cnt   <= amt;
      r_op    <= op_e'(op);
      r_carry <= 1'b0;
    end else if (w_step_en) begin
      r_sout  <= w_step_value;
      r_carry <= w_step_bit;
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  assign sout  = r_sout;
  assign carry = r_carry;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: driver pushes expected results, monitor checks on done.
module tb_seq_shifter;

  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] in;
  logic [2:0]       op;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] sout;
  logic             carry;
  logic             busy;
  logic             done;

  typedef struct {
    logic [15:0] s;
    logic        c;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e_mon;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [15:0] hold_s;
  logic        hold_c;
  bit          hold_vld = 0;

  seq_shifter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in),
    .op    (op),
    .amt   (amt),
    .sout  (sout),
    .carry (carry),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: whole-word shift/rotate by k computed directly.
  task automatic model(input logic [15:0] x, input logic [2:0] o, input int k,
                       output logic [15:0] r, output logic c);
    logic [31:0] w;
    r = x;
    c = 1'b0;
    case (o)
      3'd1: begin
        w = {16'b0, x} << k;
        r = w[15:0];
        c = (k == 0) ? 1'b0 : w[16];
      end
      3'd2: begin
        r = x >> k;
        c = (k == 0) ? 1'b0 : x[k-1];
      end
      3'd3: begin
        r = 16'($signed(x) >>> k);
        c = (k == 0) ? 1'b0 : x[k-1];
      end
      3'd4: begin
        r = (k == 0) ? x : 16'((x << k) | (x >> (16 - k)));
        c = (k == 0) ? 1'b0 : r[0];
      end
      3'd5: begin
        r = (k == 0) ? x : 16'((x >> k) | (x << (16 - k)));
        c = (k == 0) ? 1'b0 : r[15];
      end
      default: begin
        r = x;
        c = 1'b0;
      end
    endcase
  endtask

  task automatic push_exp(input logic [15:0] x, input logic [2:0] o, input int k, input int dcyc);
    exp_t e;
    model(x, o, k, e.s, e.c);
    e.cyc = dcyc;
    q.push_back(e);
  endtask

  task automatic issue(input logic [15:0] x, input logic [2:0] o, input logic [3:0] k, input bit push);
    @(negedge clk);
    start = 1'b1;
    in    = x;
    op    = o;
    amt   = k;
    if (push) push_exp(x, o, int'(k), cyc + int'(k) + 2);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("drain_timeout", longint'(q.size()), 0);
      q.delete();
    end
  endtask

  // Monitor: compare each done pulse against the oldest expectation, and hold behaviour while idle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        hold_vld = 0;
      end else if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", longint'(done), 0);
        end else begin
          e_mon = q.pop_front();
          check("result_sout",  longint'(sout),  longint'(e_mon.s));
          check("result_carry", longint'(carry), longint'(e_mon.c));
          check("done_latency", longint'(cyc),   longint'(e_mon.cyc));
          hold_s   = sout;
          hold_c   = carry;
          hold_vld = 1;
        end
      end else if (!busy && hold_vld) begin
        check("hold_sout",  longint'(sout),  longint'(hold_s));
        check("hold_carry", longint'(carry), longint'(hold_c));
      end
    end
  end

  // Driver.
  initial begin
    logic [15:0] x;
    logic [2:0]  o;
    logic [3:0]  k;
    reset = 1'b1;
    start = 1'b0;
    in    = '0;
    op    = '0;
    amt   = '0;
    repeat (3) @(negedge clk);
    check("reset_sout",  longint'(sout),  0);
    check("reset_carry", longint'(carry), 0);
    check("reset_busy",  longint'(busy),  0);
    check("reset_done",  longint'(done),  0);
    reset = 1'b0;

    // Directed vectors on the reference operand.
    issue(16'hF0CF, 3'b001, 4'd1,  1); wait_drain();
    issue(16'hF0CF, 3'b010, 4'd1,  1); wait_drain();
    issue(16'hF0CF, 3'b011, 4'd1,  1); wait_drain();
    issue(16'hF0CF, 3'b101, 4'd4,  1); wait_drain();
    issue(16'hF0CF, 3'b100, 4'd4,  1); wait_drain();
    issue(16'hF0CF, 3'b011, 4'd15, 1); wait_drain();
    issue(16'hF0CF, 3'b000, 4'd9,  1); wait_drain();
    issue(16'hF0CF, 3'b111, 4'd9,  1); wait_drain();
    issue(16'hF0CF, 3'b001, 4'd0,  1); wait_drain();
    issue(16'hF0CF, 3'b001, 4'd15, 1); wait_drain();
    issue(16'hF0CF, 3'b101, 4'd15, 1); wait_drain();
    issue(16'h8001, 3'b110, 4'd3,  1); wait_drain();

    // Start and new operands during busy must be ignored.
    issue(16'hF0CF, 3'b001, 4'd8, 1);
    start = 1'b1;
    in    = 16'h1234;
    op    = 3'b101;
    amt   = 4'd3;
    repeat (4) begin
      @(negedge clk);
      check("busy_during_op", longint'(busy), 1);
    end
    start = 1'b0;
    wait_drain();

    // Reset in the middle of an operation aborts it with no done pulse.
    issue(16'hF0CF, 3'b001, 4'd8, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_sout",  longint'(sout),  0);
    check("abort_carry", longint'(carry), 0);
    check("abort_busy",  longint'(busy),  0);
    check("abort_done",  longint'(done),  0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_idle_busy", longint'(busy), 0);

    // Start held through DONE: second operation accepted in the DONE cycle.
    @(negedge clk);
    start = 1'b1;
    in    = 16'hF0CF;
    op    = 3'b101;
    amt   = 4'd4;
    push_exp(16'hF0CF, 3'b101, 4, cyc + 6);
    push_exp(16'h1234, 3'b001, 3, cyc + 6 + 5);
    @(negedge clk);
    in  = 16'h1234;
    op  = 3'b001;
    amt = 4'd3;
    repeat (5) @(negedge clk);
    check("b2b_done_seen", longint'(done), 1);
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Randomized operations.
    repeat (40) begin
      x = 16'($urandom);
      o = 3'($urandom_range(0, 7));
      k = 4'($urandom_range(0, 15));
      issue(x, o, k, 1);
      wait_drain();
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits (legal values: 2 to 64).
REQ-002 SHALL have derived constant AW = clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin an operation; sampled only when busy=0.
REQ-006 SHALL have port in  input  WIDTH  operand; captured on an accepted start.
REQ-007 SHALL have port op  input  3  mode code: 000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROL, 101 ROR; 110 and 111 act as pass.
REQ-008 SHALL have port amt  input  AW  shift distance 0..WIDTH-1; captured on an accepted start.
REQ-009 SHALL have port sout  output  WIDTH  working/result register.
REQ-010 SHALL have port carry  output  1  last bit shifted or rotated out.
REQ-011 SHALL have port busy  output  1  high while an operation is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking a valid result.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE; busy=1 exactly in SHIFT.
REQ-014 SHALL, in IDLE or DONE with start=1, load sout<=in, cnt<=amt, op register<=op, carry<=0, and enter SHIFT.
REQ-015 SHALL, in SHIFT with cnt!=0, apply a one-bit step per the registered op and decrement cnt.
REQ-016 SHALL, in SHIFT with cnt==0, enter DONE without modifying sout.
REQ-017 SHALL assert done only in DONE, for one cycle; DONE returns to IDLE unless start=1 (REQ-014 applies).
REQ-018 SHALL assert done k+1 cycles after the accepted start edge for amt=k; amt=0 gives 1 cycle and sout=in.
REQ-019 SHALL perform these one-bit steps: LSL shifts 0 into bit0; LSR shifts 0 into the MSB; ASR replicates the MSB; ROL moves the MSB to bit0; ROR moves bit0 to the MSB; pass holds the value.
REQ-020 SHALL update carry on each step to the bit leaving the register (the MSB for LSL/ROL, bit0 for LSR/ASR/ROR); carry stays 0 for pass.
REQ-021 SHALL ignore start, in, op and amt while busy=1; the registered op and amt hold for the whole operation.
REQ-022 SHALL hold sout and carry stable from DONE until the next accepted start.
REQ-023 SHALL give a result exactly equal to the equivalent combinational shift or rotate by amt, including amt=WIDTH-1.

Reset
REQ-024 SHALL, when reset=1 at a clock edge, force state to IDLE and sout=0, carry=0, busy=0, done=0, cnt=0; reset takes priority over start.
REQ-025 SHALL treat reset mid-SHIFT as an abort: no done pulse, and the partial result is discarded.

Structure
REQ-026 SHALL place the op encodings and the state encoding in shared package shifter_pkg.
REQ-027 SHALL instantiate one combinational sub-module shift_step (inputs value, op; outputs next value, out-bit), parametrised by WIDTH.

Verification (WIDTH=16, in=16'hF0CF)
REQ-028 SHALL check: op=001, amt=1 -> done 2 cycles after start, sout=16'hE19E, carry=1.
REQ-029 SHALL check: op=010, amt=1 -> sout=16'h7867, carry=1; op=011, amt=1 -> sout=16'hF867, carry=1.
REQ-030 SHALL check: op=101, amt=4 -> done 5 cycles after start, sout=16'hFF0C, carry=1; op=100, amt=4 -> sout=16'h0CFF, carry=1.
REQ-031 SHALL check: op=011, amt=15 -> sout=16'hFFFF; op=000 or op=111, amt=9 -> sout=16'hF0CF, carry=0.
REQ-032 SHALL check: second start with in=16'h1234 raised during busy -> ignored, first result unchanged; reset asserted at cycle 3 of an amt=8 operation -> next cycle sout=0, busy=0, and no done pulse.
REQ-033 SHALL check: start held high through DONE -> back-to-back operation accepted in the DONE cycle, with one done pulse per operation.
